// File: rtl/span_pkg.sv
// Shared widths, payload types and state encoding for the spread tier accumulator.
package span_pkg;

    localparam int unsigned NUM_LEGS  = 8;
    localparam int unsigned NUM_TIERS = 3;
    localparam int unsigned QTY_W     = 16;
    localparam int unsigned MAT_W     = 8;
    localparam int unsigned TIER_W    = 4;
    localparam int unsigned MAG_W     = 16;
    localparam int unsigned CNT_W     = $clog2(NUM_LEGS + 1);
    localparam int unsigned IDX_W     = $clog2(NUM_LEGS);
    localparam int unsigned ERR_W     = 3;

    localparam int unsigned ERR_OVF   = 0;
    localparam int unsigned ERR_UNBKT = 1;
    localparam int unsigned ERR_TRUNC = 2;

    typedef struct packed {
        logic [QTY_W-1:0] qty;
        logic [MAT_W-1:0] mat;
    } leg_t;

    typedef logic [NUM_TIERS-1:0][MAG_W-1:0]  tier_sum_t;
    typedef logic [NUM_TIERS-1:0][TIER_W-1:0] tier_max_t;
    typedef logic [NUM_LEGS-1:0][QTY_W-1:0]   pos_arr_t;
    typedef logic [NUM_LEGS-1:0][MAT_W-1:0]   mat_arr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PRESENT = 2'd2
    } acc_state_e;

endpackage

// File: rtl/spread_tier_accumulator_if.sv
// Leg input stream and portfolio bundle output stream of the spread tier accumulator.
interface spread_tier_accumulator_if;
    import span_pkg::*;

    logic               leg_valid;
    logic               leg_ready;
    logic [QTY_W-1:0]   leg_qty;
    logic [MAT_W-1:0]   leg_mat;
    logic               leg_last;
    logic               out_valid;
    logic               out_ready;
    tier_sum_t          tier_long;
    tier_sum_t          tier_short;
    pos_arr_t           position;
    mat_arr_t           maturity;
    logic [CNT_W-1:0]   leg_count;
    logic [ERR_W-1:0]   err_flags;

    modport master (
        output leg_valid, leg_qty, leg_mat, leg_last, out_ready,
        input  leg_ready, out_valid, tier_long, tier_short, position, maturity,
               leg_count, err_flags
    );

    modport slave (
        input  leg_valid, leg_qty, leg_mat, leg_last, out_ready,
        output leg_ready, out_valid, tier_long, tier_short, position, maturity,
               leg_count, err_flags
    );

endinterface

// File: rtl/tier_classify.sv
// Maps one leg to its maturity tier (lowest tier with mat < bound) and unsigned magnitude.
module tier_classify
    import span_pkg::*;
(
    input  logic [MAT_W-1:0]     mat,
    input  logic [QTY_W-1:0]     qty,
    input  tier_max_t            tmax,
    output logic [NUM_TIERS-1:0] onehot_c,
    output logic                 hit_c,
    output logic [MAG_W-1:0]     mag_c,
    output logic                 is_short_c
);

    logic [QTY_W-1:0] neg_c;

    always_comb begin
        onehot_c = '0;
        hit_c    = 1'b0;
        for (int t = 0; t < int'(NUM_TIERS); t++) begin
            if (!hit_c && (mat < MAT_W'(tmax[t]))) begin
                onehot_c[t] = 1'b1;
                hit_c       = 1'b1;
            end
        end
    end

    // Negating the most negative quantity wraps to its true magnitude when read unsigned.
    assign is_short_c = qty[QTY_W-1];
    assign neg_c      = QTY_W'(~qty + QTY_W'(1));
    assign mag_c      = is_short_c ? MAG_W'(neg_c) : MAG_W'(qty);

endmodule

// File: rtl/spread_tier_accumulator.sv
// Collects one portfolio's legs, sums long/short magnitudes per maturity tier and presents the bundle.
module spread_tier_accumulator
    import span_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  tier_max_t                   tier_max,
    spread_tier_accumulator_if.slave    bus
);

    acc_state_e        state_q, state_d;
    tier_sum_t         long_q, long_d;
    tier_sum_t         short_q, short_d;
    pos_arr_t          pos_q, pos_d;
    mat_arr_t          mat_q, mat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    tier_max_t         shadow_q, shadow_d;
    logic              leg_ready_q;
    logic              out_valid_q;

    leg_t                  leg_c;
    tier_max_t             tmax_sel_c;
    logic [NUM_TIERS-1:0]  cls_onehot_c;
    logic                  cls_hit_c;
    logic [MAG_W-1:0]      cls_mag_c;
    logic                  cls_short_c;
    logic                  accept_c;
    logic                  full_c;
    logic                  done_c;
    logic [IDX_W-1:0]      idx_c;
    logic [MAG_W:0]        sum_c;

    assign leg_c = '{qty: bus.leg_qty, mat: bus.leg_mat};

    // The first leg is classified against the live bounds, later legs against the shadow copy.
    assign tmax_sel_c = (state_q == IDLE) ? tier_max : shadow_q;

    tier_classify u_classify (
        .mat        (leg_c.mat),
        .qty        (leg_c.qty),
        .tmax       (tmax_sel_c),
        .onehot_c   (cls_onehot_c),
        .hit_c      (cls_hit_c),
        .mag_c      (cls_mag_c),
        .is_short_c (cls_short_c)
    );

    always_comb begin
        state_d  = state_q;
        long_d   = long_q;
        short_d  = short_q;
        pos_d    = pos_q;
        mat_d    = mat_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        shadow_d = shadow_q;
        sum_c    = '0;
        accept_c = bus.leg_valid && leg_ready_q;
        full_c   = (cnt_q == CNT_W'(NUM_LEGS - 1));
        done_c   = bus.leg_last || full_c;
        idx_c    = IDX_W'(cnt_q);

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    shadow_d = tier_max;
                    state_d  = done_c ? PRESENT : ACCUM;
                end
            end
            ACCUM: begin
                if (accept_c && done_c) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (out_valid_q && bus.out_ready) begin
                    long_d  = '0;
                    short_d = '0;
                    pos_d   = '0;
                    mat_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_c) begin
            pos_d[idx_c] = leg_c.qty;
            mat_d[idx_c] = leg_c.mat;
            cnt_d        = cnt_q + CNT_W'(1);
            if (!cls_hit_c) begin
                err_d[ERR_UNBKT] = 1'b1;
            end
            if (full_c && !bus.leg_last) begin
                err_d[ERR_TRUNC] = 1'b1;
            end
            // Saturating add into the single matched tier.
            for (int t = 0; t < int'(NUM_TIERS); t++) begin
                if (cls_onehot_c[t]) begin
                    sum_c = cls_short_c ? ({1'b0, short_q[t]} + {1'b0, cls_mag_c})
                                        : ({1'b0, long_q[t]}  + {1'b0, cls_mag_c});
                    if (sum_c[MAG_W]) begin
                        err_d[ERR_OVF] = 1'b1;
                        sum_c          = {1'b0, {MAG_W{1'b1}}};
                    end
                    if (cls_short_c) begin
                        short_d[t] = sum_c[MAG_W-1:0];
                    end else begin
                        long_d[t]  = sum_c[MAG_W-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            long_q      <= '0;
            short_q     <= '0;
            pos_q       <= '0;
            mat_q       <= '0;
            cnt_q       <= '0;
            err_q       <= '0;
            shadow_q    <= '0;
            leg_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            long_q      <= long_d;
            short_q     <= short_d;
            pos_q       <= pos_d;
            mat_q       <= mat_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            shadow_q    <= shadow_d;
            leg_ready_q <= (state_d != PRESENT);
            out_valid_q <= (state_d == PRESENT);
        end
    end

    assign bus.leg_ready  = leg_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.tier_long  = long_q;
    assign bus.tier_short = short_q;
    assign bus.position   = pos_q;
    assign bus.maturity   = mat_q;
    assign bus.leg_count  = cnt_q;
    assign bus.err_flags  = err_q;

endmodule

// File: tb/tb_spread_tier_accumulator.sv
// Directed self-checking bench for spread_tier_accumulator.
module tb_spread_tier_accumulator;
    import span_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    tier_max_t tier_max;
    int        errors = 0;
    int        checks = 0;

    spread_tier_accumulator_if bus_if();

    spread_tier_accumulator dut (
        .clk      (clk),
        .reset    (reset),
        .tier_max (tier_max),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_leg(input logic [15:0] qty, input logic [7:0] mat, input logic last);
        int guard = 0;
        @(negedge clk);
        bus_if.leg_valid = 1'b1;
        bus_if.leg_qty   = qty;
        bus_if.leg_mat   = mat;
        bus_if.leg_last  = last;
        while (!bus_if.leg_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (bus_if.leg_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_leg_ready: leg_ready=%b after %0d cycles, required 1", bus_if.leg_ready, guard);
        end
        @(posedge clk);
        #1;
        bus_if.leg_valid = 1'b0;
        bus_if.leg_last  = 1'b0;
    endtask

    task automatic take_bundle();
        int guard = 0;
        @(negedge clk);
        while (!bus_if.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (bus_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL take_bundle_valid: out_valid=%b after %0d cycles, required 1", bus_if.out_valid, guard);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.leg_ready !== 1'b1 || bus_if.leg_count !== 4'd0) begin
            errors++;
            $display("FAIL take_bundle_clear: out_valid=%b leg_ready=%b leg_count=%0d, required 0 1 0",
                     bus_if.out_valid, bus_if.leg_ready, bus_if.leg_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_if.leg_ready !== 1'b0 || bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: leg_ready=%b out_valid=%b, required 0 0", bus_if.leg_ready, bus_if.out_valid);
        end
        checks++;
        if (bus_if.tier_long !== '0 || bus_if.tier_short !== '0 || bus_if.leg_count !== 4'd0 || bus_if.err_flags !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: long=%0h short=%0h count=%0d err=%b, required all 0",
                     bus_if.tier_long, bus_if.tier_short, bus_if.leg_count, bus_if.err_flags);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.leg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: leg_ready=%b, required 1", bus_if.leg_ready);
        end
    endtask

    task automatic test_basic();
        send_leg(16'd5, 8'd1, 1'b0);
        send_leg(-16'sd3, 8'd2, 1'b0);
        send_leg(16'd4, 8'd4, 1'b0);
        send_leg(-16'sd10, 8'd7, 1'b1);
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.leg_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: out_valid=%b leg_ready=%b, required 1 0", bus_if.out_valid, bus_if.leg_ready);
        end
        checks++;
        if (bus_if.tier_long !== {16'd0, 16'd4, 16'd5}) begin
            errors++;
            $display("FAIL basic_long: got %h, required %h", bus_if.tier_long, {16'd0, 16'd4, 16'd5});
        end
        checks++;
        if (bus_if.tier_short !== {16'd10, 16'd0, 16'd3}) begin
            errors++;
            $display("FAIL basic_short: got %h, required %h", bus_if.tier_short, {16'd10, 16'd0, 16'd3});
        end
        checks++;
        if (bus_if.leg_count !== 4'd4 || bus_if.err_flags !== 3'b000) begin
            errors++;
            $display("FAIL basic_count_err: count=%0d err=%b, required 4 000", bus_if.leg_count, bus_if.err_flags);
        end
        checks++;
        if (bus_if.position[3] !== 16'hFFF6 || bus_if.maturity[3] !== 8'd7 || bus_if.position[4] !== 16'h0000) begin
            errors++;
            $display("FAIL basic_arrays: pos3=%h mat3=%0d pos4=%h, required fff6 7 0000",
                     bus_if.position[3], bus_if.maturity[3], bus_if.position[4]);
        end
        take_bundle();
        checks++;
        if (bus_if.tier_long !== '0 || bus_if.tier_short !== '0 || bus_if.position !== '0) begin
            errors++;
            $display("FAIL basic_cleared: long=%h short=%h, required 0", bus_if.tier_long, bus_if.tier_short);
        end
    endtask

    task automatic test_truncate();
        for (int i = 0; i < 8; i++) begin
            send_leg(16'd1, 8'd0, 1'b0);
        end
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.tier_long !== {16'd0, 16'd0, 16'd8} ||
            bus_if.err_flags !== 3'b100 || bus_if.leg_count !== 4'd8) begin
            errors++;
            $display("FAIL trunc_bundle: valid=%b long=%h err=%b count=%0d, required 1 %h 100 8",
                     bus_if.out_valid, bus_if.tier_long, bus_if.err_flags, bus_if.leg_count, {16'd0, 16'd0, 16'd8});
        end
        @(negedge clk);
        bus_if.leg_valid = 1'b1;
        bus_if.leg_qty   = 16'd7;
        bus_if.leg_mat   = 8'd4;
        bus_if.leg_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus_if.leg_count !== 4'd8 || bus_if.leg_ready !== 1'b0 || bus_if.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL trunc_stall: cycle %0d count=%0d ready=%b valid=%b, required 8 0 1",
                         i, bus_if.leg_count, bus_if.leg_ready, bus_if.out_valid);
            end
        end
        @(negedge clk);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        checks++;
        if (bus_if.leg_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.leg_count !== 4'd0) begin
            errors++;
            $display("FAIL trunc_release: ready=%b valid=%b count=%0d, required 1 0 0",
                     bus_if.leg_ready, bus_if.out_valid, bus_if.leg_count);
        end
        @(posedge clk);
        #1;
        bus_if.leg_valid = 1'b0;
        bus_if.leg_last  = 1'b0;
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.tier_long !== {16'd0, 16'd7, 16'd0} ||
            bus_if.leg_count !== 4'd1 || bus_if.err_flags !== 3'b000) begin
            errors++;
            $display("FAIL trunc_held_beat: valid=%b long=%h count=%0d err=%b, required 1 %h 1 000",
                     bus_if.out_valid, bus_if.tier_long, bus_if.leg_count, bus_if.err_flags, {16'd0, 16'd7, 16'd0});
        end
        take_bundle();
    endtask

    task automatic test_unbucketed();
        send_leg(16'hFFFE, 8'd9, 1'b1);
        checks++;
        if (bus_if.tier_long !== '0 || bus_if.tier_short !== '0) begin
            errors++;
            $display("FAIL unbkt_sums: long=%h short=%h, required 0", bus_if.tier_long, bus_if.tier_short);
        end
        checks++;
        if (bus_if.position[0] !== 16'hFFFE || bus_if.maturity[0] !== 8'd9 ||
            bus_if.err_flags !== 3'b010 || bus_if.leg_count !== 4'd1) begin
            errors++;
            $display("FAIL unbkt_capture: pos0=%h mat0=%0d err=%b count=%0d, required fffe 9 010 1",
                     bus_if.position[0], bus_if.maturity[0], bus_if.err_flags, bus_if.leg_count);
        end
        take_bundle();
    endtask

    task automatic test_saturate();
        send_leg(16'd30000, 8'd0, 1'b0);
        send_leg(16'd30000, 8'd0, 1'b0);
        send_leg(16'd30000, 8'd0, 1'b1);
        checks++;
        if (bus_if.tier_long !== {16'd0, 16'd0, 16'hFFFF} || bus_if.err_flags !== 3'b001) begin
            errors++;
            $display("FAIL sat_long: long=%h err=%b, required %h 001",
                     bus_if.tier_long, bus_if.err_flags, {16'd0, 16'd0, 16'hFFFF});
        end
        take_bundle();
        send_leg(16'h8000, 8'd1, 1'b1);
        checks++;
        if (bus_if.tier_short !== {16'd0, 16'd0, 16'h8000} || bus_if.tier_long !== '0 ||
            bus_if.err_flags !== 3'b000 || bus_if.position[0] !== 16'h8000) begin
            errors++;
            $display("FAIL sat_minneg: short=%h long=%h err=%b pos0=%h, required %h 0 000 8000",
                     bus_if.tier_short, bus_if.tier_long, bus_if.err_flags, bus_if.position[0],
                     {16'd0, 16'd0, 16'h8000});
        end
        take_bundle();
    endtask

    task automatic test_stall_shadow();
        send_leg(16'd2, 8'd5, 1'b0);
        tier_max = {4'd10, 4'd9, 4'd8};
        send_leg(16'd3, 8'd5, 1'b1);
        checks++;
        if (bus_if.tier_long !== {16'd0, 16'd5, 16'd0}) begin
            errors++;
            $display("FAIL shadow_sums: long=%h, required %h", bus_if.tier_long, {16'd0, 16'd5, 16'd0});
        end
        @(negedge clk);
        bus_if.leg_valid = 1'b1;
        bus_if.leg_qty   = 16'd1;
        bus_if.leg_mat   = 8'd0;
        bus_if.leg_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tier_max = (i % 2 == 0) ? {4'd1, 4'd1, 4'd1} : {4'd10, 4'd9, 4'd8};
            @(posedge clk);
            #1;
            checks++;
            if (bus_if.tier_long !== {16'd0, 16'd5, 16'd0} || bus_if.leg_count !== 4'd2 ||
                bus_if.out_valid !== 1'b1 || bus_if.leg_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_stable: cycle %0d long=%h count=%0d valid=%b ready=%b, required %h 2 1 0",
                         i, bus_if.tier_long, bus_if.leg_count, bus_if.out_valid, bus_if.leg_ready,
                         {16'd0, 16'd5, 16'd0});
            end
        end
        @(negedge clk);
        tier_max = {4'd10, 4'd9, 4'd8};
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus_if.leg_valid = 1'b0;
        bus_if.leg_last  = 1'b0;
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.tier_long !== {16'd0, 16'd0, 16'd1} || bus_if.leg_count !== 4'd1) begin
            errors++;
            $display("FAIL stall_next: valid=%b long=%h count=%0d, required 1 %h 1",
                     bus_if.out_valid, bus_if.tier_long, bus_if.leg_count, {16'd0, 16'd0, 16'd1});
        end
        take_bundle();
        tier_max = {4'd9, 4'd6, 4'd3};
    endtask

    task automatic test_mid_reset();
        send_leg(16'd5, 8'd1, 1'b0);
        send_leg(16'd6, 8'd1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.tier_long !== '0 || bus_if.position !== '0 || bus_if.leg_count !== 4'd0 ||
            bus_if.leg_ready !== 1'b0 || bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: long=%h count=%0d ready=%b valid=%b, required 0 0 0 0",
                     bus_if.tier_long, bus_if.leg_count, bus_if.leg_ready, bus_if.out_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        send_leg(16'd1, 8'd1, 1'b1);
        checks++;
        if (bus_if.tier_long !== {16'd0, 16'd0, 16'd1} || bus_if.leg_count !== 4'd1 || bus_if.position[1] !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_next: long=%h count=%0d pos1=%h, required %h 1 0000",
                     bus_if.tier_long, bus_if.leg_count, bus_if.position[1], {16'd0, 16'd0, 16'd1});
        end
        take_bundle();
    endtask

    initial begin
        tier_max         = {4'd9, 4'd6, 4'd3};
        bus_if.leg_valid = 1'b0;
        bus_if.leg_qty   = '0;
        bus_if.leg_mat   = '0;
        bus_if.leg_last  = 1'b0;
        bus_if.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_truncate();
        test_unbucketed();
        test_saturate();
        test_stall_shadow();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
